bist_tpg: RTL and testbench
===========================

# bist_tpg

Built-in self-test pattern generator: the stimulus end of the BIST path whose response end is the 16-bit signature compressor. The block sequences a test session. It emits a fixed number of pseudo-random 16-bit patterns from an autonomous Galois LFSR using the same feedback taps as the compressor. In parallel it drives the compressor's enable, delayed to match the circuit-under-test latency, then flags completion.

## Interface
- `SEED`, 16'hFFFF: LFSR value loaded on reset and at session start.
- `CNT_W`, 16: width of the pattern counter and of `pat_count`.
- `CUT_LAT`, 1: response latency of the circuit under test in cycles; legal range 1..8.
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin a session; sampled only in IDLE.
- `pat_count` in CNT_W: number of patterns in the session; sampled with `start`.
- `hold` in 1: stall request; freezes pattern generation while high.
- `pattern` out 16: current LFSR state, applied to the circuit under test.
- `pattern_valid` out 1: `pattern` is a new test vector this cycle.
- `misr_enable` out 1: capture strobe for the signature compressor.
- `busy` out 1: high in RUN and FLUSH.
- `done` out 1: one-cycle completion pulse.

## Operation
- LFSR next-state, with fb = p[15]:
  - n[0] = fb
  - n[4] = p[3]^fb, n[5] = p[4]^fb, n[6] = p[5]^fb
  - all other n[i] = p[i-1]
  - No external input.
- State machine: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - On `start`, latch `pat_count` into the remaining counter and load the LFSR with SEED.
  - Go to RUN if the count is nonzero; if it is 0, go to DONE.
- RUN:
  - Each cycle with `hold`=0: `pattern_valid`=1, the LFSR advances at the clock edge, and the counter decrements.
  - When the counter reaches 0 on that edge, go to FLUSH.
  - With `hold`=1: `pattern_valid`=0; LFSR and counter frozen.
- FLUSH: lasts exactly CUT_LAT cycles, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE. The LFSR keeps its final value until the next start.
- `misr_enable` is `pattern_valid` delayed by exactly CUT_LAT cycles through a shift register. The shift register is cleared by reset only, so it keeps flushing in FLUSH.
- `start` outside IDLE is ignored; `pat_count` changes outside IDLE are ignored.
- Reset mid-session: abort immediately and return to IDLE with reset values; no `done` pulse.

## Timing
- Reset values:
  - `pattern` = SEED
  - `pattern_valid`, `misr_enable`, `busy`, `done` = 0
  - state IDLE, counter 0, delay line all 0
- `start` high at edge k (IDLE, count N>0):
  - From cycle k+1: RUN, `pattern`=SEED, `pattern_valid`=1, `busy`=1.
  - With no holds, patterns appear in cycles k+1..k+N.
  - FLUSH spans k+N+1..k+N+CUT_LAT.
  - `done` in cycle k+N+CUT_LAT+1; `busy`=0 in that cycle.
- `misr_enable` in cycle c equals `pattern_valid` in cycle c-CUT_LAT. The number of `misr_enable` cycles per session equals N exactly.
- N=0: `done` in cycle k+1; `pattern_valid` and `misr_enable` never assert.
- Counter wrap: not possible; the maximum N is 2^CNT_W-1.

## Configuration
- `TPG_SEED_LOAD_EN` defined:
  - Adds input port `seed_in[15:0]`.
  - At `start` in IDLE, the LFSR loads `seed_in`. If `seed_in`==0 it loads SEED instead, because all-zero is the LFSR lock-up state.
- Undefined: no `seed_in` port; the LFSR always loads SEED at start.

## Test plan
- Reset, then `start` with N=3, CUT_LAT=1, no hold:
  - Patterns FFFF, FF8F, FF6F in consecutive cycles.
  - `misr_enable` high 3 cycles, lagging one cycle behind.
  - `done` 5 cycles after the start edge.
- N=4 with `hold` high for 2 cycles after the first pattern:
  - Pattern stays FF8F with `pattern_valid`=0 during the hold.
  - Total `pattern_valid`=4 and `misr_enable`=4.
  - `done` 2 cycles later than the unheld run.
- N=0: `done` the cycle after `start`; `busy`, `pattern_valid`, `misr_enable` stay 0.
- `start` reasserted mid-RUN and `pat_count` changed: no effect; the session completes with the original N.
- `reset` asserted mid-RUN:
  - Next cycle all outputs at reset values, `pattern`=FFFF, no `done`.
  - A subsequent `start` restarts from FFFF.
- `TPG_SEED_LOAD_EN` defined:
  - `seed_in`=0001 yields first pattern 0001, then 0002.
  - `seed_in`=0000 yields FFFF.

Source files
------------

// File: rtl/bist_tpg_if.sv
// Pattern-generator session/bus signals between a BIST controller and bist_tpg.
// The seed_in member exists only when TPG_SEED_LOAD_EN is defined.
interface bist_tpg_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] pat_count;
    logic             hold;
`ifdef TPG_SEED_LOAD_EN
    logic [15:0]      seed_in;
`endif
    logic [15:0]      pattern;
    logic             pattern_valid;
    logic             misr_enable;
    logic             busy;
    logic             done;

    modport master (
`ifdef TPG_SEED_LOAD_EN
        output seed_in,
`endif
        output start, pat_count, hold,
        input  pattern, pattern_valid, misr_enable, busy, done
    );

    modport slave (
`ifdef TPG_SEED_LOAD_EN
        input  seed_in,
`endif
        input  start, pat_count, hold,
        output pattern, pattern_valid, misr_enable, busy, done
    );
endinterface

// File: rtl/bist_tpg.sv
// BIST test-pattern generator: Galois LFSR session sequencer with CUT-latency-matched MISR enable.
// Optional macro TPG_SEED_LOAD_EN adds a run-time seed (seed_in) loaded at session start.
module bist_tpg #(
    parameter logic [15:0] SEED    = 16'hFFFF,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned CUT_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    bist_tpg_if.slave  tpg
);
    localparam int unsigned FL_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FL_W-1:0]    flush_q;
    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_d;
    logic [15:0]        seed_d;
    logic [CUT_LAT-1:0] dly_q;
    logic               busy_q;
    logic               done_q;
    logic               pv_c;
    logic               fb;

    // Galois step, taps shared with the signature compressor
    always_comb begin
        fb          = lfsr_q[15];
        lfsr_d      = {lfsr_q[14:0], fb};
        lfsr_d[6:4] = lfsr_q[5:3] ^ {3{fb}};
    end

    // All-zero seed would lock the LFSR, so fall back to SEED
    always_comb begin
        seed_d = SEED;
`ifdef TPG_SEED_LOAD_EN
        if (tpg.seed_in != 16'h0000) seed_d = tpg.seed_in;
`endif
    end

    assign pv_c = (state_q == S_RUN) && !tpg.hold;

    // Delay line is cleared only by reset so it drains during FLUSH
    always_ff @(posedge clk) begin
        if (reset) dly_q <= '0;
        else       dly_q <= CUT_LAT'({dly_q, pv_c});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            flush_q <= '0;
            lfsr_q  <= SEED;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tpg.start) begin
                        cnt_q  <= tpg.pat_count;
                        lfsr_q <= seed_d;
                        if (tpg.pat_count != '0) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!tpg.hold) begin
                        lfsr_q <= lfsr_d;
                        cnt_q  <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= S_FLUSH;
                            flush_q <= FL_W'(CUT_LAT - 1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        flush_q <= flush_q - FL_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tpg.pattern       = lfsr_q;
    assign tpg.pattern_valid = pv_c;
    assign tpg.misr_enable   = dly_q[CUT_LAT-1];
    assign tpg.busy          = busy_q;
    assign tpg.done          = done_q;
endmodule

// File: tb/tb_bist_tpg.sv
// Directed, table-driven bench for bist_tpg (CUT_LAT=1 main instance, CUT_LAT=3 latency instance).
module tb_bist_tpg;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bist_tpg_if #(.CNT_W(16)) ifa ();
    bist_tpg_if #(.CNT_W(16)) ifb ();

    bist_tpg #(.SEED(16'hFFFF), .CNT_W(16), .CUT_LAT(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .tpg   (ifa.slave)
    );

    bist_tpg #(.SEED(16'hFFFF), .CNT_W(16), .CUT_LAT(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .tpg   (ifb.slave)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic [15:0] cnt;
        logic        hold;
        logic [15:0] pat;
        logic        pv;
        logic        me;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic rst, input logic st, input logic [15:0] cnt,
                               input logic hd, input logic [15:0] pat, input logic pv,
                               input logic me, input logic bz, input logic dn);
        vec_t r;
        r.rst = rst; r.start = st; r.cnt = cnt; r.hold = hd;
        r.pat = pat; r.pv = pv; r.me = me; r.busy = bz; r.done = dn;
        return r;
    endfunction

    // Independent bit-by-bit model of the LFSR step
    function automatic logic [15:0] lfsr_next(input logic [15:0] p);
        logic [15:0] n;
        logic        f;
        f = p[15];
        for (int i = 1; i < 16; i++) n[i] = p[i-1];
        n[0] = f;
        n[4] = p[3] ^ f;
        n[5] = p[4] ^ f;
        n[6] = p[5] ^ f;
        return n;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_pat;

        reset         = 1'b1;
        ifa.start     = 1'b0;
        ifa.pat_count = '0;
        ifa.hold      = 1'b0;
        ifb.start     = 1'b0;
        ifb.pat_count = '0;
        ifb.hold      = 1'b0;
`ifdef TPG_SEED_LOAD_EN
        ifa.seed_in   = 16'h0000;
        ifb.seed_in   = 16'h0000;
`endif

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.pattern",   ifa.pattern,             16'hFFFF);
        chk("rst.pv",        16'(ifa.pattern_valid),  16'h0);
        chk("rst.me",        16'(ifa.misr_enable),    16'h0);
        chk("rst.busy",      16'(ifa.busy),           16'h0);
        chk("rst.done",      16'(ifa.done),           16'h0);
        chk("rst_b.pattern", ifb.pattern,             16'hFFFF);
        next_cycle();

        //              rst st  cnt   hd  pattern    pv me bz dn
        // N=3 session
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'd3, 0, 16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFFFF, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFF8F, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFF6F, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFEAF, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFEAF, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFEAF, 0, 0, 0, 0));
        // N=4 with two hold cycles after the first pattern
        vecs.push_back(v(0, 1, 16'd4, 0, 16'hFEAF, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFFFF, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 1, 16'hFF8F, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 1, 16'hFF8F, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFF8F, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFF6F, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFEAF, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFD2F, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFD2F, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFD2F, 0, 0, 0, 0));
        // N=0
        vecs.push_back(v(0, 1, 16'd0, 0, 16'hFD2F, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFFFF, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFFFF, 0, 0, 0, 0));
        // N=2 with start/pat_count disturbed mid-RUN
        vecs.push_back(v(0, 1, 16'd2, 0, 16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'd5, 0, 16'hFFFF, 1, 0, 1, 0));
        vecs.push_back(v(0, 1, 16'd7, 0, 16'hFF8F, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFF6F, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFF6F, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFF6F, 0, 0, 0, 0));
        // Reset mid-RUN, then restart with N=1
        vecs.push_back(v(0, 1, 16'd3, 0, 16'hFF6F, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFFFF, 1, 0, 1, 0));
        vecs.push_back(v(1, 0, 16'd0, 0, 16'hFF8F, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 16'd1, 0, 16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFFFF, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFF8F, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFF8F, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 16'd0, 0, 16'hFF8F, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            reset         = vecs[i].rst;
            ifa.start     = vecs[i].start;
            ifa.pat_count = vecs[i].cnt;
            ifa.hold      = vecs[i].hold;
            @(negedge clk);
            chk($sformatf("v%0d.pattern", i), ifa.pattern,            vecs[i].pat);
            chk($sformatf("v%0d.pv", i),      16'(ifa.pattern_valid), 16'(vecs[i].pv));
            chk($sformatf("v%0d.me", i),      16'(ifa.misr_enable),   16'(vecs[i].me));
            chk($sformatf("v%0d.busy", i),    16'(ifa.busy),          16'(vecs[i].busy));
            chk($sformatf("v%0d.done", i),    16'(ifa.done),          16'(vecs[i].done));
            next_cycle();
        end
        reset     = 1'b0;
        ifa.start = 1'b0;
        ifa.hold  = 1'b0;

        // Longer N=20 run against the LFSR model
        ifa.start     = 1'b1;
        ifa.pat_count = 16'd20;
        next_cycle();
        ifa.start = 1'b0;
        exp_pat   = 16'hFFFF;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk($sformatf("long%0d.pattern", j), ifa.pattern, exp_pat);
            chk($sformatf("long%0d.pv", j), 16'(ifa.pattern_valid), 16'h1);
            exp_pat = lfsr_next(exp_pat);
            next_cycle();
        end
        @(negedge clk);
        chk("long.flush_pattern", ifa.pattern, exp_pat);
        chk("long.flush_busy", 16'(ifa.busy), 16'h1);
        next_cycle();
        @(negedge clk);
        chk("long.done", 16'(ifa.done), 16'h1);
        next_cycle();

        // CUT_LAT=3 instance: N=3, misr_enable lags three cycles, done at offset 7
        ifb.start     = 1'b1;
        ifb.pat_count = 16'd3;
        next_cycle();
        ifb.start = 1'b0;
        for (int off = 1; off <= 9; off++) begin
            @(negedge clk);
            chk($sformatf("lat3.%0d.pv", off),   16'(ifb.pattern_valid), 16'(off >= 1 && off <= 3));
            chk($sformatf("lat3.%0d.me", off),   16'(ifb.misr_enable),   16'(off >= 4 && off <= 6));
            chk($sformatf("lat3.%0d.busy", off), 16'(ifb.busy),          16'(off >= 1 && off <= 6));
            chk($sformatf("lat3.%0d.done", off), 16'(ifb.done),          16'(off == 7));
            next_cycle();
        end

`ifdef TPG_SEED_LOAD_EN
        ifa.seed_in   = 16'h0001;
        ifa.start     = 1'b1;
        ifa.pat_count = 16'd2;
        next_cycle();
        ifa.start = 1'b0;
        @(negedge clk);
        chk("seed1.first", ifa.pattern, 16'h0001);
        next_cycle();
        @(negedge clk);
        chk("seed1.second", ifa.pattern, 16'h0002);
        repeat (3) next_cycle();
        ifa.seed_in   = 16'h0000;
        ifa.start     = 1'b1;
        ifa.pat_count = 16'd1;
        next_cycle();
        ifa.start = 1'b0;
        @(negedge clk);
        chk("seed0.first", ifa.pattern, 16'hFFFF);
        chk("seed0.pv", 16'(ifa.pattern_valid), 16'h1);
        repeat (3) next_cycle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
